mips_instr_issue: RTL
=====================

Name: mips_instr_issue

Overview:
Instruction-side producer for the MIPS datapath. It holds a small instruction memory, fetches words under a PC counter and splits each word into R/I/J fields (OpCode, rs, rt, rd, shamt, funct, imm, target). It hands one decoded instruction per valid/ready transaction to the execute blocks (I-type and R-type executors). It is the sending end of the field interface that those executors consume.

Parameters:
DEPTH, 64, instruction memory depth in 32-bit words (power of two, >= 4)
AW, 6, PC/address width, equal to log2(DEPTH)
HALT_WORD, 32'hFFFF_FFFF, instruction word that stops issue

Ports:
clk  input  1  system clock, all state updates on posedge
reset  input  1  synchronous, active-high reset
prog_we  input  1  instruction memory write enable (accepted only in IDLE/HALTED)
prog_addr  input  AW  write address
prog_data  input  32  instruction word to store
start  input  1  single-cycle pulse: begin issue from PC 0
valid  output  1  decoded fields below are valid
ready  input  1  consumer accepts fields this cycle
OpCode  output  6  instr[31:26]
rs  output  5  instr[25:21]
rt  output  5  instr[20:16]
rd  output  5  instr[15:11]
shamt  output  5  instr[10:6]
funct  output  6  instr[5:0]
imm  output  16  instr[15:0]
target  output  26  instr[25:0]
itype  output  2  00 R-type (OpCode 0), 01 I-type, 10 J-type (OpCode 2 or 3), 11 halt
pc  output  AW  word address of the instruction on the outputs
busy  output  1  high in FETCH/ISSUE
halted  output  1  high in HALTED

Behaviour:
- Reset (sync, active-high): state IDLE, pc=0, valid=0, busy=0, halted=0, all field outputs 0, itype=00. Memory contents are not cleared.
- Memory: synchronous write in IDLE/HALTED when prog_we=1. Read has one-cycle latency (registered read of mem[pc]). prog_we in FETCH/ISSUE is ignored.
- FSM:
  - IDLE: wait for start. Then go to FETCH with pc=0.
  - FETCH: one cycle for the memory read. Next cycle go to ISSUE with fields registered from the word read and valid=1.
  - ISSUE: hold all outputs stable while valid=1 and ready=0. When valid and ready are both high, the transfer completes in that cycle.
- Next PC after a transfer:
  - J-type: pc = target[AW-1:0].
  - Otherwise: pc = pc+1, wrapping mod DEPTH.
  - After a transfer the FSM returns to FETCH (valid=0). Throughput is therefore one instruction per 2 cycles minimum.
- Halt:
  - A fetched word equal to HALT_WORD is not issued. valid stays 0, itype=11, and the FSM moves to HALTED.
  - Fetching address DEPTH-1 and then wrapping to 0 via increment also enters HALTED after that instruction's transfer completes.
  - A J-type to 0 does not halt.
- HALTED: halted=1. start restarts at pc=0 (goes to FETCH).
- start while busy is ignored. start and prog_we in the same IDLE cycle: the write happens and the FSM moves to FETCH.
- Reset mid-ISSUE drops the pending instruction and returns to IDLE with valid=0 next cycle.
- imm is raw (no sign extension). Sign/zero extension is the consumer's job.

Decomposition:
- Shared package (mips_pkg): opcode constants (OP_RTYPE=0, OP_J=2, OP_JAL=3, OP_ADDI=8), itype encodings, FSM state encoding, HALT_WORD default.
- One sub-module: mips_imem (DEPTH x 32, one sync write port, one registered read port).

Test Plan:
1. Program the words 0x20220005 (addi), 0x00221820 (add), 0xFFFFFFFF, then start with ready=1 held high.
   - First transfer: OpCode=8, rs=1, rt=2, imm=0x0005, itype=01, pc=0.
   - Second transfer: OpCode=0, rd=3, funct=0x20, itype=00, pc=1.
   - Then halted=1 and no third valid.
2. Backpressure: hold ready=0 for 5 cycles while valid=1 → outputs and pc remain unchanged. Raise ready → exactly one transfer occurs.
3. Program a J-type 0x08000004 at address 0 and an addi at address 4 → after the jump transfer (itype=10, target=4), the next pc is 4.
4. Pulse reset while valid=1 in ISSUE → next cycle valid=0, pc=0, state IDLE. A following start re-issues from address 0.
5. With DEPTH=4, fill all four words with non-halt addi → four transfers (pc 0..3), then halted=1.
6. Assert prog_we during ISSUE at the address currently being issued → the memory is unchanged. Re-reading that address after halt and restart returns the original word.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS instruction-issue slice: opcode constants,
// instruction-class encodings, issue FSM states and the word classifier.
package mips_pkg;

    localparam logic [5:0]  OP_RTYPE = 6'd0;
    localparam logic [5:0]  OP_J     = 6'd2;
    localparam logic [5:0]  OP_JAL   = 6'd3;
    localparam logic [5:0]  OP_ADDI  = 6'd8;

    localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ITYPE_R    = 2'b00,
        ITYPE_I    = 2'b01,
        ITYPE_J    = 2'b10,
        ITYPE_HALT = 2'b11
    } itype_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_ISSUE  = 2'd2,
        ST_HALTED = 2'd3
    } state_e;

    // The halt word wins over opcode decoding, since its opcode field is not 0/2/3.
    function automatic itype_e classify(input logic [31:0] word,
                                        input logic [31:0] halt_word);
        itype_e t;
        if (word == halt_word)
            t = ITYPE_HALT;
        else if (word[31:26] == OP_RTYPE)
            t = ITYPE_R;
        else if (word[31:26] == OP_J || word[31:26] == OP_JAL)
            t = ITYPE_J;
        else
            t = ITYPE_I;
        return t;
    endfunction

endpackage

// File: rtl/mips_imem.sv
// Instruction memory: DEPTH x 32 bits, one synchronous write port and one
// enabled, registered read port (one-cycle read latency).
module mips_imem #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        if (re)
            rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mips_instr_issue.sv
// Instruction fetch/issue front end: reads words from a local instruction memory
// under a PC and hands decoded R/I/J fields to the executors over valid/ready.
//
// state     | meaning
// IDLE      | waiting for start; memory may be programmed
// FETCH     | registered memory read of mem[pc] has landed, decode it
// ISSUE     | fields valid, holding until ready
// HALTED    | halt word or PC wrap seen; memory may be programmed, start restarts
module mips_instr_issue
    import mips_pkg::*;
#(
    parameter int          DEPTH     = 64,
    parameter int          AW        = 6,
    parameter logic [31:0] HALT_WORD = HALT_WORD_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [31:0]   prog_data,
    input  logic          start,
    output logic          valid,
    input  logic          ready,
    output logic [5:0]    OpCode,
    output logic [4:0]    rs,
    output logic [4:0]    rt,
    output logic [4:0]    rd,
    output logic [4:0]    shamt,
    output logic [5:0]    funct,
    output logic [15:0]   imm,
    output logic [25:0]   target,
    output logic [1:0]    itype,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          halted
);

    localparam logic [AW-1:0] PC_LAST = AW'(DEPTH - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [31:0]   instr_q, instr_d;
    itype_e        itype_q, itype_d;

    logic          mem_we;
    logic          rd_en;
    logic [31:0]   rd_data;

    mips_imem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_imem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (prog_addr),
        .wdata (prog_data),
        .re    (rd_en),
        .raddr (pc_d),
        .rdata (rd_data)
    );

    // The read is launched on the edge that enters FETCH, addressed by the next PC,
    // so the word is already in the read register during the FETCH cycle.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        itype_d = itype_q;
        mem_we  = 1'b0;
        rd_en   = 1'b0;

        case (state_q)
            ST_IDLE, ST_HALTED: begin
                mem_we = prog_we;
                if (start) begin
                    state_d = ST_FETCH;
                    pc_d    = '0;
                    rd_en   = 1'b1;
                end
            end

            ST_FETCH: begin
                instr_d = rd_data;
                itype_d = classify(rd_data, HALT_WORD);
                if (rd_data == HALT_WORD)
                    state_d = ST_HALTED;
                else
                    state_d = ST_ISSUE;
            end

            ST_ISSUE: begin
                if (ready) begin
                    if (itype_q == ITYPE_J) begin
                        pc_d    = instr_q[AW-1:0];
                        state_d = ST_FETCH;
                        rd_en   = 1'b1;
                    end else begin
                        pc_d = pc_q + AW'(1);
                        if (pc_q == PC_LAST) begin
                            state_d = ST_HALTED;
                        end else begin
                            state_d = ST_FETCH;
                            rd_en   = 1'b1;
                        end
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            instr_q <= '0;
            itype_q <= ITYPE_R;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            itype_q <= itype_d;
        end
    end

    assign valid  = (state_q == ST_ISSUE);
    assign busy   = (state_q == ST_FETCH) || (state_q == ST_ISSUE);
    assign halted = (state_q == ST_HALTED);
    assign OpCode = instr_q[31:26];
    assign rs     = instr_q[25:21];
    assign rt     = instr_q[20:16];
    assign rd     = instr_q[15:11];
    assign shamt  = instr_q[10:6];
    assign funct  = instr_q[5:0];
    assign imm    = instr_q[15:0];
    assign target = instr_q[25:0];
    assign itype  = itype_q;
    assign pc     = pc_q;

endmodule
